// File: rtl/reset_release_pkg.sv
// Shared constants and types for the reset-release timebase: default chain
// depth, default counter width and the default-width counter word.
package reset_release_pkg;

    localparam int unsigned default_num_stages_lp = 3;
    localparam int unsigned default_ctr_width_lp  = 32;

    typedef logic [default_ctr_width_lp-1:0] ctr_t;

endpackage

// File: rtl/reset_release_cycle_counter_if.sv
// Bundle between the host side (drives done_i) and the timebase block
// (returns the delayed core reset and the global cycle count).
interface reset_release_cycle_counter_if #(
    parameter int unsigned ctr_width_p = 32
);

    // Level signals only, no valid/ready handshake: done_i is sampled every
    // edge, and core_reset_o / ctr_r_o are valid in every cycle.
    logic                   done_i;
    logic                   core_reset_o;
    logic [ctr_width_p-1:0] ctr_r_o;

    modport master (
        output done_i,
        input  core_reset_o,
        input  ctr_r_o
    );

    modport slave (
        input  done_i,
        output core_reset_o,
        output ctr_r_o
    );

endinterface

// File: rtl/reset_release_dff_chain.sv
// Width-generic shift register. Every stage loads preset_p while reset_n_i is low.
// A depth of zero collapses to a combinational wire.
module reset_release_dff_chain #(
    parameter int unsigned          width_p  = 1,
    parameter int unsigned          els_p    = 3,
    parameter logic [width_p-1:0]   preset_p = '1
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    generate
        if (els_p == 0) begin : g_pass
            // Pure pass-through: clock and reset intentionally have no effect.
            logic unused_clk_rst;
            assign unused_clk_rst = &{1'b0, clk_i, reset_n_i};
            assign data_o = data_i;
        end else begin : g_chain
            logic [width_p-1:0] stage_r [els_p];

            always_ff @(posedge clk_i) begin
                if (!reset_n_i) begin
                    for (int k = 0; k < int'(els_p); k++) begin
                        stage_r[k] <= preset_p;
                    end
                end else begin
                    stage_r[0] <= data_i;
                    for (int k = 1; k < int'(els_p); k++) begin
                        stage_r[k] <= stage_r[k-1];
                    end
                end
            end

            assign data_o = stage_r[els_p-1];
        end
    endgenerate

endmodule

// File: rtl/reset_release_cycle_counter.sv
// Delays ~done into a core-side reset and runs a global cycle counter that
// is held at init_val_p while that core-side reset is asserted.
module reset_release_cycle_counter
    import reset_release_pkg::*;
#(
    parameter int unsigned             num_stages_p = default_num_stages_lp,
    parameter int unsigned             ctr_width_p  = default_ctr_width_lp,
    parameter logic [ctr_width_p-1:0]  init_val_p   = '0
) (
    input  logic                                 clk_i,
    input  logic                                 reset_n_i,
    reset_release_cycle_counter_if.slave         bus
);

    typedef logic [ctr_width_p-1:0] ctr_word_t;

    logic      done_n;
    logic      core_reset;
    ctr_word_t ctr_r;

    assign done_n = ~bus.done_i;

    // Presetting to 1 keeps the cores in reset until the chain refills with done.
    reset_release_dff_chain #(
        .width_p  (1),
        .els_p    (num_stages_p),
        .preset_p (1'b1)
    ) u_chain (
        .clk_i     (clk_i),
        .reset_n_i (reset_n_i),
        .data_i    (done_n),
        .data_o    (core_reset)
    );

    // Hold uses the current core_reset, so the first released cycle shows init_val_p.
    always_ff @(posedge clk_i) begin
        if (!reset_n_i || core_reset) begin
            ctr_r <= init_val_p;
        end else begin
            ctr_r <= ctr_r + ctr_word_t'(1);
        end
    end

    assign bus.core_reset_o = core_reset;
    assign bus.ctr_r_o      = ctr_r;

`ifndef SYNTHESIS
    always @(posedge clk_i) begin
        if (reset_n_i) begin
            assert (!$isunknown(bus.done_i))
                else $error("reset_release_cycle_counter: done_i is X/Z while out of reset");
        end
    end
`endif

endmodule

// File: tb/tb_reset_release_cycle_counter.sv
// Directed bench for reset_release_cycle_counter: several parameter sets
// driven from one linear sequence, with hand-computed expectations.
module reset_release_clock_gen #(
    parameter int unsigned cycle_time_p = 1000
) (
    output logic o
);
    initial o = 1'b0;
    always #(cycle_time_p / 2) o = ~o;
endmodule

module tb_reset_release_cycle_counter;
    import reset_release_pkg::*;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    // ---------------- clock / reset ----------------
    reset_release_clock_gen #(.cycle_time_p(1000)) u_clk (.o(clk));

    // a: defaults; b: 4-bit wrap; c: init 5; d: zero-depth pass-through, init 7
    reset_release_cycle_counter_if #(.ctr_width_p(32)) if_a ();
    reset_release_cycle_counter_if #(.ctr_width_p(4))  if_b ();
    reset_release_cycle_counter_if #(.ctr_width_p(8))  if_c ();
    reset_release_cycle_counter_if #(.ctr_width_p(8))  if_d ();

    reset_release_cycle_counter #(.num_stages_p(3), .ctr_width_p(32), .init_val_p(32'd0)) dut_a (
        .clk_i(clk), .reset_n_i(rst_n), .bus(if_a));
    reset_release_cycle_counter #(.num_stages_p(3), .ctr_width_p(4), .init_val_p(4'd0)) dut_b (
        .clk_i(clk), .reset_n_i(rst_n), .bus(if_b));
    reset_release_cycle_counter #(.num_stages_p(3), .ctr_width_p(8), .init_val_p(8'd5)) dut_c (
        .clk_i(clk), .reset_n_i(rst_n), .bus(if_c));
    reset_release_cycle_counter #(.num_stages_p(0), .ctr_width_p(8), .init_val_p(8'd7)) dut_d (
        .clk_i(clk), .reset_n_i(rst_n), .bus(if_d));

    // ---------------- driver / checker tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input ctr_t obs, input ctr_t exp);
        total++;
        assert (obs === exp)
            else begin
                bad++;
                $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        if_a.done_i = 1'b0;
        if_b.done_i = 1'b0;
        if_c.done_i = 1'b0;
        if_d.done_i = 1'b0;

        // Power-up reset, then idle with done low
        for (int i = 0; i < 4; i++) begin
            step();
            chk("pwr_core_a", ctr_t'(if_a.core_reset_o), 1);
            chk("pwr_ctr_a",  if_a.ctr_r_o, 0);
        end
        rst_n = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("idle_core_a", ctr_t'(if_a.core_reset_o), 1);
            chk("idle_ctr_a",  if_a.ctr_r_o, 0);
            chk("idle_core_d", ctr_t'(if_d.core_reset_o), 1);
            chk("idle_ctr_d",  ctr_t'(if_d.ctr_r_o), 7);
        end

        // Release latency: done sampled at edge E, core_reset low after E+2
        if_a.done_i = 1'b1;
        if_b.done_i = 1'b1;
        if_c.done_i = 1'b1;
        step();
        chk("rel_e0_core", ctr_t'(if_a.core_reset_o), 1);
        step();
        chk("rel_e1_core", ctr_t'(if_a.core_reset_o), 1);
        step();
        chk("rel_e2_core", ctr_t'(if_a.core_reset_o), 0);
        chk("rel_e2_ctr_a", if_a.ctr_r_o, 0);
        chk("rel_e2_ctr_b", ctr_t'(if_b.ctr_r_o), 0);
        chk("rel_e2_ctr_c", ctr_t'(if_c.ctr_r_o), 5);
        step();
        chk("rel_e3_ctr_a", if_a.ctr_r_o, 1);
        chk("rel_e3_ctr_c", ctr_t'(if_c.ctr_r_o), 6);
        step();
        chk("rel_e4_ctr_a", if_a.ctr_r_o, 2);
        chk("rel_e4_ctr_b", ctr_t'(if_b.ctr_r_o), 2);

        // 4-bit wrap: ... 15, 0, 1
        for (int i = 3; i <= 17; i++) begin
            step();
            chk("wrap_ctr_b", ctr_t'(if_b.ctr_r_o), ctr_t'(i % 16));
            chk("run_ctr_a",  if_a.ctr_r_o, ctr_t'(i));
        end

        // Re-assert: done falls at 20, counter runs 21,22,23 then holds
        step(); step(); step();
        chk("pre_fall_ctr_a", if_a.ctr_r_o, 20);
        if_a.done_i = 1'b0;
        step();
        chk("fall_ctr_21", if_a.ctr_r_o, 21);
        chk("fall_core_0", ctr_t'(if_a.core_reset_o), 0);
        step();
        chk("fall_ctr_22", if_a.ctr_r_o, 22);
        step();
        chk("fall_ctr_23", if_a.ctr_r_o, 23);
        chk("fall_core_1", ctr_t'(if_a.core_reset_o), 1);
        step();
        chk("fall_hold_0", if_a.ctr_r_o, 0);
        step();
        chk("fall_hold_1", if_a.ctr_r_o, 0);

        // Mid-run reset with done held high, at count 100
        if_a.done_i = 1'b1;
        step(); step(); step();
        chk("rerel_core", ctr_t'(if_a.core_reset_o), 0);
        chk("rerel_ctr",  if_a.ctr_r_o, 0);
        repeat (100) step();
        chk("at_100_ctr", if_a.ctr_r_o, 100);
        rst_n = 1'b0;
        step();
        chk("mid_rst_core_a", ctr_t'(if_a.core_reset_o), 1);
        chk("mid_rst_ctr_a",  if_a.ctr_r_o, 0);
        chk("mid_rst_core_b", ctr_t'(if_b.core_reset_o), 1);
        chk("mid_rst_ctr_c",  ctr_t'(if_c.ctr_r_o), 5);
        rst_n = 1'b1;
        step();
        chk("refill_e0_core", ctr_t'(if_a.core_reset_o), 1);
        step();
        chk("refill_e1_core", ctr_t'(if_a.core_reset_o), 1);
        step();
        chk("refill_e2_core", ctr_t'(if_a.core_reset_o), 0);
        chk("refill_e2_ctr",  if_a.ctr_r_o, 0);
        step();
        chk("refill_e3_ctr",  if_a.ctr_r_o, 1);

        // Zero-depth pass-through
        chk("pt_core_idle", ctr_t'(if_d.core_reset_o), 1);
        chk("pt_ctr_idle",  ctr_t'(if_d.ctr_r_o), 7);
        if_d.done_i = 1'b1;
        #1;
        chk("pt_core_rise", ctr_t'(if_d.core_reset_o), 0);
        chk("pt_ctr_rise",  ctr_t'(if_d.ctr_r_o), 7);
        step();
        chk("pt_ctr_8", ctr_t'(if_d.ctr_r_o), 8);
        step();
        chk("pt_ctr_9", ctr_t'(if_d.ctr_r_o), 9);
        if_d.done_i = 1'b0;
        #1;
        chk("pt_core_fall", ctr_t'(if_d.core_reset_o), 1);
        step();
        chk("pt_ctr_hold", ctr_t'(if_d.ctr_r_o), 7);

        // ---------------- report ----------------
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
